// File: rtl/regfile_display_scanner.sv
// Purpose: sweeps the register-file read port over words 0..3 and shows each word as a hex digit on a 4-digit mux display.
// Latency: address presented on the edge entering SETUP; data captured and anode lit on the next edge; each digit lit REFRESH_COUNT+1 cycles.
// Backpressure: none; free-running scan, freeze parks on the current digit, blank darkens anodes without disturbing timing.
//
// Ports:
//   clk, clr          : rising-edge clock, synchronous active-high reset
//   readData          : register file read data (combinational from readAddress)
//   blank, freeze     : darken all digits / hold scan on the current digit
//   readAddress       : registered read address into the register file
//   an, seg, dp       : active-low anodes (one-hot-zero), segments {g,f,e,d,c,b,a}, decimal point
//   digit_idx         : index of the digit currently being scanned (debug)
module regfile_display_scanner #(
  parameter int REFRESH_COUNT = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       readData,
  input  logic             blank,
  input  logic             freeze,
  output logic [1:0]       readAddress,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [1:0]       digit_idx
);

  // SETUP: address is on the read port for this cycle.
  // LATCH: entered on the edge that captured readData and lit the anode.
  // HOLD : digit stays lit while the refresh counter runs.
  typedef enum logic [1:0] {SETUP, LATCH, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       addr_q, addr_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             terminal;
  logic [3:0]       an_lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign terminal = (cnt_q == CNT_W'(REFRESH_COUNT - 1));
  // Anode pattern for the current digit, overridden by blank.
  assign an_lit   = blank ? 4'b1111 : ~(4'b0001 << idx_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    an_d    = an_q;
    seg_d   = seg_q;
    case (state_q)
      SETUP: begin
        // Address has been stable for a full cycle: capture and light.
        addr_d  = idx_q;
        seg_d   = hex7(readData);
        an_d    = an_lit;
        state_d = LATCH;
      end
      LATCH: begin
        cnt_d   = '0;
        an_d    = an_lit;
        state_d = HOLD;
      end
      HOLD: begin
        if (terminal) begin
          // One dark cycle between digits avoids ghosting; freeze re-reads the same word.
          cnt_d   = '0;
          an_d    = 4'b1111;
          state_d = SETUP;
          if (!freeze) begin
            idx_d  = idx_q + 2'd1;
            addr_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          an_d  = an_lit;
        end
      end
      default: state_d = SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= SETUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      addr_q  <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign readAddress = addr_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = 1'b1;
  assign digit_idx   = idx_q;

endmodule

// File: tb/tb_regfile_display_scanner.sv
module tb_regfile_display_scanner;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       clr, blank, freeze;
  logic [3:0] readData;
  logic [1:0] readAddress, digit_idx;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [3:0] mem [4];
  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int tests = 0;
  int fails = 0;

  regfile_display_scanner #(.REFRESH_COUNT(RC), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .readData(readData), .blank(blank), .freeze(freeze),
    .readAddress(readAddress), .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  // Register file read port: combinational from the DUT's address.
  assign readData = mem[readAddress];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each digit slot is RC+2 cycles long; position 0 is the
  // dark address-setup cycle, positions 1..RC+1 show the digit.
  bit         m_on = 1'b0;
  int         m_pos, m_idx;
  logic [3:0] m_an, m_lit;
  logic [6:0] m_seg;

  always @(posedge clk) begin
    if (clr) begin
      m_on = 1'b1; m_pos = 0; m_idx = 0; m_an = 4'hF; m_seg = 7'h7F;
    end else if (m_on) begin
      m_lit = blank ? 4'hF : ~(4'b0001 << m_idx);
      if (m_pos == 0) begin
        m_seg = HEX[mem[m_idx]];
        m_an  = m_lit;
        m_pos = 1;
      end else if (m_pos == RC + 1) begin
        m_an  = 4'hF;
        if (!freeze) m_idx = (m_idx + 1) % 4;
        m_pos = 0;
      end else begin
        m_an  = m_lit;
        m_pos = m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_an",     32'(an),          32'(m_an));
      chk("m_seg",    32'(seg),         32'(m_seg));
      chk("m_addr",   32'(readAddress), 32'(m_idx));
      chk("m_idx",    32'(digit_idx),   32'(m_idx));
      chk("m_dp",     32'(dp),          32'd1);
      chk("an_1hot0", 32'($countones(~an) <= 1), 32'd1);
    end
  end

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    while (an !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(an), 32'(target));
  endtask

  task automatic wait_leave(input logic [3:0] target);
    int n = 0;
    while (an === target && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    clr = 1'b1; blank = 1'b0; freeze = 1'b0;
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'hA; mem[3] = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_an",   32'(an),          32'hF);
    chk("rst_seg",  32'(seg),         32'h7F);
    chk("rst_addr", 32'(readAddress), 32'd0);
    chk("rst_idx",  32'(digit_idx),   32'd0);
    chk("rst_dp",   32'(dp),          32'd1);

    // Basic scan: hand-computed per-edge expectations after release.
    clr = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      case (k)
        1:  begin chk("s1_an", 32'(an), 32'hE); chk("s1_seg", 32'(seg), 32'h79); chk("s1_ra", 32'(readAddress), 32'd0); end
        5:  chk("s5_an", 32'(an), 32'hE);
        6:  begin chk("s6_an", 32'(an), 32'hF); chk("s6_ra", 32'(readAddress), 32'd1); end
        7:  begin chk("s7_an", 32'(an), 32'hD); chk("s7_seg", 32'(seg), 32'h24); end
        13: begin chk("s13_an", 32'(an), 32'hB); chk("s13_seg", 32'(seg), 32'h08); chk("s13_ra", 32'(readAddress), 32'd2); end
        19: begin chk("s19_an", 32'(an), 32'h7); chk("s19_seg", 32'(seg), 32'h0E); chk("s19_ra", 32'(readAddress), 32'd3); end
        24: begin chk("s24_an", 32'(an), 32'hF); chk("s24_ra", 32'(readAddress), 32'd0); end
        25: begin chk("s25_an", 32'(an), 32'hE); chk("s25_seg", 32'(seg), 32'h79); end
        default: ;
      endcase
    end

    // clr mid-scan while digit 2 is lit.
    wait_an(4'hB, "clr_wait");
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_an",   32'(an),          32'hF);
    chk("clr_seg",  32'(seg),         32'h7F);
    chk("clr_addr", 32'(readAddress), 32'd0);
    @(negedge clk);
    chk("clr_restart_an",  32'(an),  32'hE);
    chk("clr_restart_seg", 32'(seg), 32'h79);

    // Freeze on digit 1 from its LATCH cycle, rewrite word1 mid-hold.
    wait_an(4'hD, "frz_wait");
    freeze = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("frz_an", 32'(an == 4'hD || an == 4'hF), 32'd1);
      chk("frz_ra", 32'(readAddress), 32'd1);
      if (c == 8)  mem[1] = 4'h7;
      if (c == 11) chk("frz_seg_old", 32'(seg), 32'h24);
      if (c == 20) chk("frz_seg_new", 32'(seg), 32'h78);
    end
    freeze = 1'b0;

    // Blank pulse on digit 3 starting at its LATCH cycle.
    wait_an(4'h7, "blk_wait");
    blank = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("blk_an",  32'(an),  32'hF);
      chk("blk_seg", 32'(seg), 32'h0E);
    end
    blank = 1'b0;
    @(negedge clk); chk("blk_restore", 32'(an), 32'h7);
    @(negedge clk); chk("blk_gap",     32'(an), 32'hF);
    @(negedge clk); chk("blk_next",    32'(an), 32'hE);

    // Sweep all nibbles through word0.
    for (int n = 0; n < 16; n++) begin
      mem[0] = 4'(n);
      wait_leave(4'hE);
      wait_an(4'hE, "swp_wait");
      chk("swp_seg", 32'(seg), 32'(HEX[n]));
    end

    // Random data with occasional blank/freeze; model and invariants checked each cycle.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(0, 15));
      blank  = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 7) == 0);
    end
    blank = 1'b0; freeze = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
